// File: rtl/fetch_irq_vec.sv
// Instruction-fetch stage: PC, local programmable imem, IF/ID register, and a vectored
// edge-triggered interrupt controller with mask, lowest-index priority and a single EPC.
module fetch_irq_vec #(
  parameter int          NUM_IRQ    = 2,
  parameter int          IMEM_WORDS = 4096,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0004,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0004,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
  localparam int         AW         = $clog2(IMEM_WORDS),
  localparam int         IDW        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch,
  input  logic [31:0]        pc_ex,
  input  logic               rti,
  input  logic               rsi,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               prog_en,
  input  logic [31:0]        prog_addr,
  input  logic [31:0]        prog_data,
  output logic [31:0]        instruction_dec,
  output logic [31:0]        pc_dec,
  output logic               valid_dec,
  output logic               in_handler,
  output logic [IDW-1:0]     irq_id,
  output logic [31:0]        epc
);

  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        pc_dec_q, pc_dec_d;
  logic               valid_q, valid_d;
  logic               in_handler_q, in_handler_d;
  logic [IDW-1:0]     irq_id_q, irq_id_d;
  logic [31:0]        epc_q, epc_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;

  logic [31:0]        imem [IMEM_WORDS];
  logic [31:0]        fetch_word;
  logic [NUM_IRQ-1:0] req;
  logic [NUM_IRQ-1:0] take_mask;
  logic               win_found;
  logic [IDW-1:0]     win_idx;
  logic               take;
  logic [31:0]        seq_pc;
  logic [31:0]        vector_pc;
  logic               prog_addr_unused;

  // Upper address bits alias onto the same words; they are deliberately ignored.
  assign prog_addr_unused = ^{prog_addr[31:AW+2], prog_addr[1:0]};
  assign fetch_word       = imem[pc_q[AW+1:2]];

  // NOTE: the instruction memory has no reset branch -- clearing thousands of words in
  // one cycle is not realisable, and software always loads it before fetch is released.
  always_ff @(posedge clk) begin
    if (prog_en) imem[prog_addr[AW+1:2]] <= prog_data;
  end

  // Lowest enabled pending index wins.
  assign req = pending_q & irq_mask;
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_found = 1'b1;
        win_idx   = IDW'(i);
      end
    end
  end

  assign take      = win_found & ~in_handler_q & ~stall & ~prog_en;
  assign seq_pc    = branch ? pc_ex : pc_q + 32'd4;
  assign vector_pc = VEC_BASE + 32'(win_idx) * VEC_STRIDE;
  assign take_mask = take ? (NUM_IRQ'(1) << win_idx) : '0;

  // A fresh edge wins over the clear of a source taken in the same cycle.
  assign irq_prev_d = irq;
  assign pending_d  = (pending_q & ~take_mask) | (irq & ~irq_prev_q);

  always_comb begin
    // NOTE: every *_d starts as its hold value so no branch below can leave one
    // unassigned and infer a latch.
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc_dec_d     = pc_dec_q;
    valid_d      = valid_q;
    in_handler_d = in_handler_q;
    irq_id_d     = irq_id_q;
    epc_d        = epc_q;

    if (prog_en) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (!stall) begin
      if (branch || rti) begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end else begin
        instr_d  = fetch_word;
        pc_dec_d = pc_q + 32'd4;
        valid_d  = 1'b1;
      end

      if (take) begin
        pc_d         = vector_pc;
        epc_d        = seq_pc;
        in_handler_d = 1'b1;
        irq_id_d     = win_idx;
      end else begin
        pc_d = rti ? epc_q : seq_pc;
        // Outside a handler rti/rsi only steer the PC.
        if (in_handler_q && (rti || rsi)) begin
          in_handler_d = 1'b0;
          if (rsi) epc_d = '0;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      pc_dec_q     <= '0;
      valid_q      <= 1'b0;
      in_handler_q <= 1'b0;
      irq_id_q     <= '0;
      epc_q        <= '0;
      pending_q    <= '0;
      irq_prev_q   <= '0;
    end else begin
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc_dec_q     <= pc_dec_d;
      valid_q      <= valid_d;
      in_handler_q <= in_handler_d;
      irq_id_q     <= irq_id_d;
      epc_q        <= epc_d;
      pending_q    <= pending_d;
      irq_prev_q   <= irq_prev_d;
    end
  end

  assign instruction_dec = instr_q;
  assign pc_dec          = pc_dec_q;
  assign valid_dec       = valid_q;
  assign in_handler      = in_handler_q;
  assign irq_id          = irq_id_q;
  assign epc             = epc_q;

endmodule

// File: tb/tb_fetch_irq_vec.sv
// Bench for fetch_irq_vec: directed scenarios against hand-derived constants, then a
// randomized run against a behavioural model of the fetch/interrupt rules.
module tb_fetch_irq_vec;
  localparam int          NUM_IRQ    = 2;
  localparam int          IMEM_WORDS = 256;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] VEC_BASE   = 32'h0000_0004;
  localparam logic [31:0] VEC_STRIDE = 32'h0000_0004;
  localparam logic [31:0] NOP        = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst, stall, branch, rti, rsi, prog_en;
  logic [31:0] pc_ex, prog_addr, prog_data;
  logic [NUM_IRQ-1:0] irq, irq_mask;
  logic [31:0] instruction_dec, pc_dec, epc;
  logic valid_dec, in_handler;
  logic [0:0] irq_id;

  int vectors = 0;
  int miscompares = 0;

  fetch_irq_vec #(
    .NUM_IRQ(NUM_IRQ), .IMEM_WORDS(IMEM_WORDS), .RESET_PC(RESET_PC),
    .VEC_BASE(VEC_BASE), .VEC_STRIDE(VEC_STRIDE), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .pc_ex(pc_ex),
    .rti(rti), .rsi(rsi), .irq(irq), .irq_mask(irq_mask), .prog_en(prog_en),
    .prog_addr(prog_addr), .prog_data(prog_data), .instruction_dec(instruction_dec),
    .pc_dec(pc_dec), .valid_dec(valid_dec), .in_handler(in_handler),
    .irq_id(irq_id), .epc(epc)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [31:0] m_mem [IMEM_WORDS];
  logic [31:0] m_pc, m_instr, m_pcdec, m_epc;
  bit          m_valid, m_inh;
  int          m_id;
  bit          m_pend [NUM_IRQ];
  bit          m_prev [NUM_IRQ];

  function automatic logic [31:0] word(int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  function automatic void model_step();
    int win = -1;
    bit take;
    logic [31:0] seq;
    if (rst) begin
      m_pc = RESET_PC; m_instr = NOP; m_pcdec = 0; m_valid = 0;
      m_inh = 0; m_id = 0; m_epc = 0;
      for (int i = 0; i < NUM_IRQ; i++) begin m_pend[i] = 0; m_prev[i] = 0; end
    end else begin
      for (int i = 0; i < NUM_IRQ; i++) if (win < 0 && m_pend[i] && irq_mask[i]) win = i;
      take = (win >= 0) && !m_inh && !stall && !prog_en;
      seq  = branch ? pc_ex : m_pc + 4;
      for (int i = 0; i < NUM_IRQ; i++) begin
        m_pend[i] = (m_pend[i] && !(take && win == i)) || (irq[i] && !m_prev[i]);
        m_prev[i] = irq[i];
      end
      if (prog_en) begin
        m_valid = 0; m_instr = NOP;
      end else if (!stall) begin
        if (branch || rti) begin
          m_valid = 0; m_instr = NOP;
        end else begin
          m_instr = m_mem[int'((m_pc / 4) % IMEM_WORDS)];
          m_pcdec = m_pc + 4; m_valid = 1;
        end
        if (take) begin
          m_pc = VEC_BASE + 32'(win) * VEC_STRIDE;
          m_epc = seq; m_inh = 1; m_id = win;
        end else begin
          m_pc = rti ? m_epc : seq;
          if (m_inh && (rti || rsi)) begin
            m_inh = 0;
            if (rsi) m_epc = 0;
          end
        end
      end
    end
    if (prog_en) m_mem[int'((prog_addr / 4) % IMEM_WORDS)] = prog_data;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; stall = 0; branch = 0; rti = 0; rsi = 0; prog_en = 0;
    pc_ex = 0; prog_addr = 0; prog_data = 0; irq = 0; irq_mask = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic load_imem();
    do_reset();
    prog_en = 1;
    for (int i = 0; i < IMEM_WORDS; i++) begin
      prog_addr = 32'(i * 4);
      prog_data = word(i);
      tick();
    end
    prog_en = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({instruction_dec, pc_dec, valid_dec} !== {NOP, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_ifid got %h/%h/%b want %h/0/0", instruction_dec, pc_dec, valid_dec, NOP);
    end
    vectors++;
    if ({in_handler, irq_id, epc} !== {1'b0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_irq got inh=%b id=%0d epc=%h want 0/0/0", in_handler, irq_id, epc);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({instruction_dec, pc_dec, valid_dec} !== {word(i), 32'((i + 1) * 4), 1'b1}) begin
        miscompares++;
        $display("FAIL seq_fetch%0d got %h/%h/%b want %h/%h/1", i, instruction_dec, pc_dec,
                 valid_dec, word(i), (i + 1) * 4);
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    tick(); tick();
    branch = 1; pc_ex = 32'h40;
    tick();
    branch = 0;
    vectors++;
    if ({instruction_dec, valid_dec} !== {NOP, 1'b0}) begin
      miscompares++;
      $display("FAIL branch_squash got %h/%b want %h/0", instruction_dec, valid_dec, NOP);
    end
    tick();
    vectors++;
    if ({instruction_dec, pc_dec, valid_dec} !== {word(16), 32'h44, 1'b1}) begin
      miscompares++;
      $display("FAIL branch_target got %h/%h/%b want %h/44/1", instruction_dec, pc_dec, valid_dec, word(16));
    end
  endtask

  task automatic test_irq_priority();
    do_reset();
    tick(); tick(); tick();
    irq = 2'b11; irq_mask = 2'b11;
    tick();
    tick();
    vectors++;
    if ({instruction_dec, pc_dec, valid_dec, in_handler, irq_id, epc} !==
        {word(4), 32'h14, 1'b1, 1'b1, 1'b0, 32'h14}) begin
      miscompares++;
      $display("FAIL take_irq0 got %h/%h/%b inh=%b id=%0d epc=%h want %h/14/1 inh=1 id=0 epc=14",
               instruction_dec, pc_dec, valid_dec, in_handler, irq_id, epc, word(4));
    end
    tick();
    vectors++;
    if ({instruction_dec, pc_dec, valid_dec} !== {word(1), 32'h8, 1'b1}) begin
      miscompares++;
      $display("FAIL vector0_fetch got %h/%h/%b want %h/8/1", instruction_dec, pc_dec, valid_dec, word(1));
    end
    rti = 1;
    tick();
    rti = 0;
    vectors++;
    if ({valid_dec, in_handler, epc} !== {1'b0, 1'b0, 32'h14}) begin
      miscompares++;
      $display("FAIL rti got valid=%b inh=%b epc=%h want 0/0/14", valid_dec, in_handler, epc);
    end
    tick();
    vectors++;
    if ({instruction_dec, pc_dec, in_handler, irq_id, epc} !==
        {word(5), 32'h18, 1'b1, 1'b1, 32'h18}) begin
      miscompares++;
      $display("FAIL take_irq1 got %h/%h inh=%b id=%0d epc=%h want %h/18 inh=1 id=1 epc=18",
               instruction_dec, pc_dec, in_handler, irq_id, epc, word(5));
    end
    tick();
    vectors++;
    if ({instruction_dec, pc_dec, valid_dec} !== {word(2), 32'hC, 1'b1}) begin
      miscompares++;
      $display("FAIL vector1_fetch got %h/%h/%b want %h/c/1", instruction_dec, pc_dec, valid_dec, word(2));
    end
    irq = 0;
  endtask

  task automatic test_stall_irq();
    do_reset();
    tick(); tick();
    stall = 1; irq = 2'b01; irq_mask = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({instruction_dec, pc_dec, valid_dec, in_handler} !== {word(1), 32'h8, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL stall_hold%0d got %h/%h/%b inh=%b want %h/8/1 inh=0", i, instruction_dec,
                 pc_dec, valid_dec, in_handler, word(1));
      end
    end
    stall = 0;
    tick();
    vectors++;
    if ({instruction_dec, pc_dec, in_handler, irq_id, epc} !== {word(2), 32'hC, 1'b1, 1'b0, 32'hC}) begin
      miscompares++;
      $display("FAIL stall_release_take got %h/%h inh=%b id=%0d epc=%h want %h/c inh=1 id=0 epc=c",
               instruction_dec, pc_dec, in_handler, irq_id, epc, word(2));
    end
    irq = 0;
  endtask

  task automatic test_branch_irq();
    do_reset();
    tick(); tick();
    irq = 2'b01; irq_mask = 2'b01;
    tick();
    branch = 1; pc_ex = 32'h80;
    tick();
    branch = 0;
    vectors++;
    if ({valid_dec, instruction_dec, in_handler, epc} !== {1'b0, NOP, 1'b1, 32'h80}) begin
      miscompares++;
      $display("FAIL branch_take got valid=%b %h inh=%b epc=%h want 0 %h inh=1 epc=80",
               valid_dec, instruction_dec, in_handler, epc, NOP);
    end
    tick();
    vectors++;
    if ({instruction_dec, pc_dec, valid_dec} !== {word(1), 32'h8, 1'b1}) begin
      miscompares++;
      $display("FAIL branch_take_vector got %h/%h/%b want %h/8/1", instruction_dec, pc_dec, valid_dec, word(1));
    end
    rsi = 1;
    tick();
    rsi = 0;
    vectors++;
    if ({in_handler, epc, instruction_dec, pc_dec} !== {1'b0, 32'h0, word(2), 32'hC}) begin
      miscompares++;
      $display("FAIL rsi got inh=%b epc=%h %h/%h want 0/0 %h/c", in_handler, epc, instruction_dec,
               pc_dec, word(2));
    end
    tick();
    vectors++;
    if ({instruction_dec, pc_dec, valid_dec} !== {word(3), 32'h10, 1'b1}) begin
      miscompares++;
      $display("FAIL rsi_sequential got %h/%h/%b want %h/10/1", instruction_dec, pc_dec, valid_dec, word(3));
    end
    irq = 0;
  endtask

  task automatic test_prog();
    do_reset();
    tick(); tick();
    prog_en = 1; prog_addr = 32'h20; prog_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if ({instruction_dec, valid_dec} !== {NOP, 1'b0}) begin
        miscompares++;
        $display("FAIL prog_freeze%0d got %h/%b want %h/0", i, instruction_dec, valid_dec, NOP);
      end
    end
    prog_en = 0;
    tick();
    vectors++;
    if ({instruction_dec, pc_dec} !== {word(2), 32'hC}) begin
      miscompares++;
      $display("FAIL prog_pc_held got %h/%h want %h/c", instruction_dec, pc_dec, word(2));
    end
    for (int i = 0; i < 5; i++) tick();
    tick();
    vectors++;
    if ({instruction_dec, pc_dec, valid_dec} !== {32'hDEAD_BEEF, 32'h24, 1'b1}) begin
      miscompares++;
      $display("FAIL prog_readback got %h/%h/%b want deadbeef/24/1", instruction_dec, pc_dec, valid_dec);
    end
    // High address bits alias: this lands on word 9 (byte 0x24), the current PC.
    prog_en = 1; prog_addr = 32'hFFFF_FC24; prog_data = 32'h1234_5678;
    tick();
    prog_en = 0;
    tick();
    vectors++;
    if ({instruction_dec, pc_dec} !== {32'h1234_5678, 32'h28}) begin
      miscompares++;
      $display("FAIL prog_wrap got %h/%h want 12345678/28", instruction_dec, pc_dec);
    end
  endtask

  task automatic test_reset_mid_handler();
    do_reset();
    irq = 2'b11; irq_mask = 2'b11;
    tick(); tick();
    vectors++;
    if (in_handler !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_enter got inh=%b want 1", in_handler);
    end
    rst = 1; irq = 0;
    tick();
    rst = 0;
    vectors++;
    if ({in_handler, irq_id, epc, valid_dec} !== {1'b0, 1'b0, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL midrst_clear got inh=%b id=%0d epc=%h valid=%b want 0/0/0/0",
               in_handler, irq_id, epc, valid_dec);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({in_handler, instruction_dec, pc_dec} !== {1'b0, word(i), 32'((i + 1) * 4)}) begin
        miscompares++;
        $display("FAIL midrst_lost%0d got inh=%b %h/%h want 0 %h/%h", i, in_handler,
                 instruction_dec, pc_dec, word(i), (i + 1) * 4);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    irq_mask = 2'b11;
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 199) == 0);
      stall   = ($urandom_range(0, 99) < 15);
      branch  = ($urandom_range(0, 99) < 10);
      pc_ex   = $urandom & 32'hFFFF_FFFC;
      rti     = ($urandom_range(0, 99) < 6);
      rsi     = ($urandom_range(0, 99) < 6);
      prog_en = ($urandom_range(0, 99) < 4);
      prog_addr = $urandom;
      prog_data = $urandom;
      if ($urandom_range(0, 99) < 20) irq[$urandom_range(0, NUM_IRQ - 1)] ^= 1'b1;
      if ($urandom_range(0, 99) < 5) irq_mask = NUM_IRQ'($urandom);
      tick();
      vectors++;
      if ({instruction_dec, pc_dec, valid_dec} !== {m_instr, m_pcdec, m_valid}) begin
        miscompares++;
        $display("FAIL rand_ifid cyc %0d got %h/%h/%b want %h/%h/%b", n, instruction_dec, pc_dec,
                 valid_dec, m_instr, m_pcdec, m_valid);
      end
      vectors++;
      if ({in_handler, irq_id, epc} !== {m_inh, 1'(m_id), m_epc}) begin
        miscompares++;
        $display("FAIL rand_irq cyc %0d got inh=%b id=%0d epc=%h want inh=%b id=%0d epc=%h", n,
                 in_handler, irq_id, epc, m_inh, m_id, m_epc);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    load_imem();
    test_reset();
    test_sequential();
    test_branch();
    test_irq_priority();
    test_stall_irq();
    test_branch_irq();
    test_prog();
    test_reset_mid_handler();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
